// File: rtl/alul_if.sv
// alul_if: operand/select inputs and registered result/flag outputs of the logic unit
interface alul_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       SEL;
  logic             in_valid;
  logic [WIDTH-1:0] OUT;
  logic             out_valid;
  logic             zero;
  logic             parity;
  modport master (output A, B, SEL, in_valid, input OUT, out_valid, zero, parity);
  modport slave  (input A, B, SEL, in_valid, output OUT, out_valid, zero, parity);
endinterface

// File: rtl/alul.sv
// alul: registered bitwise AND/OR/XOR/NOT unit with valid, zero and parity flags
module alul #(parameter int WIDTH = 8) (
  input logic   clk,
  input logic   rst_n,
  alul_if.slave bus
);
  logic [WIDTH-1:0] res_d, out_q;
  logic             valid_q, zero_q, parity_q;
  always_comb begin
    res_d = '0;
    case (bus.SEL)
      2'b00:   res_d = bus.A & bus.B;
      2'b01:   res_d = bus.A | bus.B;
      2'b10:   res_d = bus.A ^ bus.B;
      2'b11:   res_d = ~bus.A;
      default: res_d = '0;
    endcase
  end
  // result and flags hold when idle; only out_valid drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q    <= res_d;
        zero_q   <= (res_d == '0);
        parity_q <= ^res_d;
      end
    end
  end
  assign bus.OUT       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
endmodule

// File: tb/tb_alul.sv
// tb_alul: directed vectors with hand-computed results for the registered logic unit
module tb_alul;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  alul_if #(.WIDTH(8)) bus ();
  alul #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask
  task automatic apply(input string tag, input logic rn, input logic v,
                       input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                       input logic [7:0] e_out, input logic e_ov, input logic e_z, input logic e_p);
    rst_n = rn;
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    bus.SEL = sel;
    @(posedge clk);
    #1;
    check({tag, ".out"},    bus.OUT, e_out);
    check({tag, ".valid"},  {7'b0, bus.out_valid}, {7'b0, e_ov});
    check({tag, ".zero"},   {7'b0, bus.zero}, {7'b0, e_z});
    check({tag, ".parity"}, {7'b0, bus.parity}, {7'b0, e_p});
  endtask
  initial begin
    bus.A = 8'h00;
    bus.B = 8'h00;
    bus.SEL = 2'b00;
    bus.in_valid = 1'b0;
    apply("rst0", 1'b0, 1'b1, 8'hFF, 8'hFF, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("rst1", 1'b0, 1'b1, 8'hFF, 8'hFF, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("and",  1'b1, 1'b1, 8'h0F, 8'h05, 2'b00, 8'h05, 1'b1, 1'b0, 1'b0);
    apply("or",   1'b1, 1'b1, 8'h0F, 8'h05, 2'b01, 8'h0F, 1'b1, 1'b0, 1'b0);
    apply("xor",  1'b1, 1'b1, 8'h0F, 8'h05, 2'b10, 8'h0A, 1'b1, 1'b0, 1'b0);
    apply("not0", 1'b1, 1'b1, 8'h0F, 8'h05, 2'b11, 8'hF0, 1'b1, 1'b0, 1'b0);
    apply("not1", 1'b1, 1'b1, 8'hAA, 8'h00, 2'b11, 8'h55, 1'b1, 1'b0, 1'b0);
    apply("xor1", 1'b1, 1'b1, 8'hFF, 8'h80, 2'b10, 8'h7F, 1'b1, 1'b0, 1'b1);
    apply("zero", 1'b1, 1'b1, 8'hF0, 8'h0F, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
    apply("hold0", 1'b1, 1'b0, 8'h12, 8'h34, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0);
    apply("hold1", 1'b1, 1'b0, 8'h56, 8'h78, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
    apply("hold2", 1'b1, 1'b0, 8'h9A, 8'hBC, 2'b11, 8'h00, 1'b0, 1'b1, 1'b0);
    apply("par",  1'b1, 1'b1, 8'h01, 8'h00, 2'b01, 8'h01, 1'b1, 1'b0, 1'b1);
    apply("mrst", 1'b0, 1'b1, 8'h01, 8'h00, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("post", 1'b1, 1'b0, 8'hFF, 8'hFF, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("new",  1'b1, 1'b1, 8'h3C, 8'h0F, 2'b01, 8'h3F, 1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alul.md
Name: alul

Overview:
- Registered 8-bit bitwise logic unit. It is the logic half of the ALU datapath.
- Each cycle it computes AND, OR, XOR or NOT of operands A/B, selected by SEL.
- Result is registered with 1-cycle latency, plus valid and status flags.
- Single clock domain; synchronous active-low reset.

Parameters:
- WIDTH, 8, operand/result width in bits. All test values below use 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- SEL  input  2  operation select
- in_valid  input  1  A/B/SEL are valid this cycle; capture and compute
- OUT  output  WIDTH  registered result
- out_valid  output  1  OUT updated with a new result this cycle
- zero  output  1  registered flag: result just computed was all zeros
- parity  output  1  registered flag: XOR-reduction of result just computed

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low on rst_n. Reset is sampled only on a rising clk edge; no asynchronous path.
- Operation decode, combinational from A, B, SEL:
  - SEL=00 -> A & B
  - SEL=01 -> A | B
  - SEL=10 -> A ^ B
  - SEL=11 -> ~A; B is ignored
- All operations are purely bitwise. No carry, no width growth; the result is exactly WIDTH bits.
- Rising clk edge with rst_n=0: OUT=0, out_valid=0, zero=0, parity=0. This overrides in_valid.
- Rising clk edge with rst_n=1 and in_valid=1:
  - OUT <= decoded result
  - out_valid <= 1
  - zero <= (result == 0)
  - parity <= ^result
- Rising clk edge with rst_n=1 and in_valid=0: OUT, zero and parity hold their previous values; out_valid <= 0.
- Latency is exactly 1 cycle: a value presented at edge N appears on OUT after edge N.
- Throughput: one result per cycle. Back-to-back in_valid is fully supported; there is no backpressure.
- Outputs depend only on registered state. There is no combinational path from inputs to outputs.
- Reset mid-stream: any result in flight is discarded; the first post-reset output requires a new in_valid.
- In the SEL=11 case, zero and parity are computed on ~A.
- X/undefined SEL is not a supported input. The decode uses a full case with no latch; a default branch drives 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=FF -> OUT=00, out_valid=0, zero=0, parity=0 throughout.
- AND: A=0F, B=05, SEL=00, in_valid=1 -> next cycle OUT=05, out_valid=1, zero=0, parity=0.
- OR then XOR back-to-back, A=0F, B=05:
  - SEL=01 -> OUT=0F, parity=0
  - next cycle SEL=10 -> OUT=0A, parity=0
  - out_valid stays 1 on both cycles
- NOT: A=0F, B=05, SEL=11 -> OUT=F0, parity=0. Then A=AA, B=00, SEL=11 -> OUT=55.
- Zero/hold: A=F0, B=0F, SEL=00 -> OUT=00, zero=1. Then in_valid=0 for 3 cycles with changing A/B -> OUT=00 and zero=1 held, out_valid=0.
- Parity: A=01, B=00, SEL=01 -> OUT=01, parity=1. Then assert rst_n=0 for one cycle -> OUT=00, parity=0, out_valid=0.
